program_encoder: RTL and testbench

Streaming instruction encoder and program-memory loader for the picoMIPS core. It accepts decoded instruction fields (opcode, destination and source register, immediate) over a valid/ready handshake. It checks each opcode against the implemented set and packs legal ones into instruction words. It writes those words sequentially into program memory, producing exactly the words the core's instruction decoder consumes.

---
 rtl/program_encoder.sv | 132 +++++++++++++
 tb/tb_program_encoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_encoder.sv
// Streaming instruction encoder and program-memory loader for the picoMIPS core.
// Optional running XOR checksum of written words: define PROGRAM_ENCODER_CHECKSUM_EN.
module program_encoder #(
    parameter int RW    = 3,
    parameter int IW    = 8,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int WW   = 3 + 2 * RW + IW
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [2:0]    opcode,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] rs,
    input  logic [IW-1:0] imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [WW-1:0] mem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err,
    output logic [WW-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] addr_q;
    logic [WW-1:0] wdata_q;
    logic          we_q;
    logic [AW:0]   count_q;
    logic          err_q;
    logic          accept;
    logic          legal;
    logic          last_slot;
    logic [WW-1:0] word;

    // Unused fields of each instruction format are zeroed so the decoder sees canonical words.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (opcode)
            3'b000:                 word = '0;
            3'b001, 3'b011, 3'b100: word = {opcode, rd, {RW{1'b0}}, imm};
            3'b010:                 word = {opcode, rd, rs, {IW{1'b0}}};
            default:                legal = 1'b0;
        endcase
    end

    assign in_ready  = (state_q == FILL);
    assign accept    = in_valid && in_ready;
    assign last_slot = (wr_ptr == PTR_LAST);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start)
            state_d = FILL;
        else if (accept && (in_last || (legal && last_slot)))
            state_d = DONE;
    end

    // wr_ptr saturates at the last slot; the FSM leaves FILL on that write, so it never wraps.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q)
                count_q <= count_q + CNT_ONE;
            if (start) begin
                wr_ptr  <= '0;
                addr_q  <= '0;
                count_q <= '0;
                err_q   <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    we_q    <= 1'b1;
                    addr_q  <= wr_ptr;
                    wdata_q <= word;
                    if (!last_slot)
                        wr_ptr <= wr_ptr + PTR_ONE;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign done      = (state_q == DONE);

`ifdef PROGRAM_ENCODER_CHECKSUM_EN
    logic [WW-1:0] csum_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            csum_q <= '0;
        else if (start)
            csum_q <= '0;
        else if (we_q)
            csum_q <= csum_q ^ wdata_q;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_encoder.sv
// Directed self-checking bench for program_encoder: single-instruction vector table
// plus hand-written sequences for streaming, illegal opcodes, memory full and reset.
module tb_program_encoder;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [2:0]    opcode;
    logic [2:0]    rd;
    logic [2:0]    rs;
    logic [7:0]    imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [16:0]   mem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          err;
    logic [16:0]   checksum;

    int n_cmp = 0;
    int n_err = 0;

    program_encoder #(.RW(3), .IW(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .opcode(opcode), .rd(rd), .rs(rs),
        .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [7:0]  imm;
        logic        exp_we;
        logic [16:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                                  input logic [7:0] im, input logic last);
        in_valid = 1'b1;
        opcode   = op;
        rd       = d;
        rs       = s;
        imm      = im;
        in_last  = last;
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    function automatic logic [16:0] exp_csum(input logic [16:0] x);
`ifdef PROGRAM_ENCODER_CHECKSUM_EN
        return x;
`else
        return 17'h0;
`endif
    endfunction

    logic [16:0] w_add, w_muli, w_load, w_acc;
    int          writes;
    logic        addr_ok;

    initial begin
        vecs[0] = '{"addi",  3'b001, 3'd1, 3'd0, 8'h05, 1'b1, {3'b001, 3'd1, 3'd0, 8'h05}, 1'b0};
        vecs[1] = '{"nop",   3'b000, 3'd5, 3'd3, 8'hAA, 1'b1, 17'h0,                       1'b0};
        vecs[2] = '{"add",   3'b010, 3'd2, 3'd1, 8'h33, 1'b1, {3'b010, 3'd2, 3'd1, 8'h00}, 1'b0};
        vecs[3] = '{"muli",  3'b011, 3'd2, 3'd4, 8'h03, 1'b1, {3'b011, 3'd2, 3'd0, 8'h03}, 1'b0};
        vecs[4] = '{"load",  3'b100, 3'd7, 3'd6, 8'hFF, 1'b1, {3'b100, 3'd7, 3'd0, 8'hFF}, 1'b0};
        vecs[5] = '{"ill101", 3'b101, 3'd1, 3'd1, 8'h11, 1'b0, 17'h0,                      1'b1};
        vecs[6] = '{"ill110", 3'b110, 3'd2, 3'd2, 8'h22, 1'b0, 17'h0,                      1'b1};
        vecs[7] = '{"ill111", 3'b111, 3'd3, 3'd3, 8'h33, 1'b0, 17'h0,                      1'b1};

        n_reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        opcode = 3'b0; rd = 3'b0; rs = 3'b0; imm = 8'h0;
        tick(); tick();
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_mem_we", 32'(mem_we), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_output("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_checksum", 32'(checksum), 32'd0);
        n_reset = 1'b1;
        tick();

        // Bundle offered in IDLE is ignored
        apply_stimulus(3'b001, 3'd1, 3'd0, 8'h01, 1'b1);
        tick();
        in_valid = 1'b0;
        check_output("idle_no_we", 32'(mem_we), 32'd0);
        check_output("idle_no_ready", 32'(in_ready), 32'd0);
        check_output("idle_count", 32'(count), 32'd0);

        for (int i = 0; i < 8; i++) begin
            pulse_start();
            check_output({vecs[i].name, "_ready"}, 32'(in_ready), 32'd1);
            check_output({vecs[i].name, "_err_clr"}, 32'(err), 32'd0);
            apply_stimulus(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, 1'b1);
            tick();
            in_valid = 1'b0;
            check_output({vecs[i].name, "_we"}, 32'(mem_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check_output({vecs[i].name, "_addr"}, 32'(mem_addr), 32'd0);
                check_output({vecs[i].name, "_word"}, 32'(mem_wdata), 32'(vecs[i].exp_word));
            end
            check_output({vecs[i].name, "_done"}, 32'(done), 32'd1);
            check_output({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
            tick();
            check_output({vecs[i].name, "_we_off"}, 32'(mem_we), 32'd0);
            check_output({vecs[i].name, "_count"}, 32'(count), 32'(vecs[i].exp_we));
            check_output({vecs[i].name, "_csum"}, 32'(checksum), 32'(exp_csum(vecs[i].exp_word)));
        end

        // Back-to-back ADD, MULI, LOAD
        w_add  = {3'b010, 3'd2, 3'd1, 8'h00};
        w_muli = {3'b011, 3'd2, 3'd0, 8'h03};
        w_load = {3'b100, 3'd7, 3'd0, 8'hFF};
        pulse_start();
        apply_stimulus(3'b010, 3'd2, 3'd1, 8'h5A, 1'b0);
        tick();
        check_output("b2b_we0", 32'(mem_we), 32'd1);
        check_output("b2b_addr0", 32'(mem_addr), 32'd0);
        check_output("b2b_word0", 32'(mem_wdata), 32'(w_add));
        apply_stimulus(3'b011, 3'd2, 3'd5, 8'h03, 1'b0);
        tick();
        check_output("b2b_we1", 32'(mem_we), 32'd1);
        check_output("b2b_addr1", 32'(mem_addr), 32'd1);
        check_output("b2b_word1", 32'(mem_wdata), 32'(w_muli));
        check_output("b2b_count1", 32'(count), 32'd1);
        apply_stimulus(3'b100, 3'd7, 3'd7, 8'hFF, 1'b1);
        tick();
        in_valid = 1'b0;
        check_output("b2b_we2", 32'(mem_we), 32'd1);
        check_output("b2b_addr2", 32'(mem_addr), 32'd2);
        check_output("b2b_word2", 32'(mem_wdata), 32'(w_load));
        check_output("b2b_done", 32'(done), 32'd1);
        tick();
        check_output("b2b_count3", 32'(count), 32'd3);
        check_output("b2b_we_off", 32'(mem_we), 32'd0);
        check_output("b2b_csum", 32'(checksum), 32'(exp_csum(w_add ^ w_muli ^ w_load)));

        // Illegal opcode between two legal ones
        pulse_start();
        apply_stimulus(3'b001, 3'd1, 3'd2, 8'h05, 1'b0);
        tick();
        check_output("ill_we0", 32'(mem_we), 32'd1);
        check_output("ill_addr0", 32'(mem_addr), 32'd0);
        apply_stimulus(3'b110, 3'd4, 3'd4, 8'h44, 1'b0);
        tick();
        check_output("ill_no_we", 32'(mem_we), 32'd0);
        check_output("ill_err", 32'(err), 32'd1);
        check_output("ill_not_done", 32'(done), 32'd0);
        apply_stimulus(3'b010, 3'd3, 3'd4, 8'h99, 1'b1);
        tick();
        in_valid = 1'b0;
        check_output("ill_we1", 32'(mem_we), 32'd1);
        check_output("ill_addr1", 32'(mem_addr), 32'd1);
        check_output("ill_word1", 32'(mem_wdata), 32'({3'b010, 3'd3, 3'd4, 8'h00}));
        tick();
        check_output("ill_count", 32'(count), 32'd2);
        check_output("ill_err_sticky", 32'(err), 32'd1);

        // Stream DEPTH+3 bundles without in_last
        pulse_start();
        writes  = 0;
        addr_ok = 1'b1;
        w_acc   = '0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            apply_stimulus(3'b001, 3'(i), 3'd0, 8'(i), 1'b0);
            if (i < DEPTH)
                w_acc = w_acc ^ {3'b001, 3'(i), 3'd0, 8'(i)};
            tick();
            if (mem_we) begin
                if (32'(mem_addr) != writes) addr_ok = 1'b0;
                writes++;
            end
        end
        in_valid = 1'b0;
        tick();
        check_output("full_writes", 32'(writes), 32'(DEPTH));
        check_output("full_addr_seq", 32'(addr_ok), 32'd1);
        check_output("full_ready", 32'(in_ready), 32'd0);
        check_output("full_done", 32'(done), 32'd1);
        check_output("full_count", 32'(count), 32'(DEPTH));
        check_output("full_last_addr", 32'(mem_addr), 32'(DEPTH - 1));
        check_output("full_csum", 32'(checksum), 32'(exp_csum(w_acc)));

        // Bundle offered in DONE is ignored
        apply_stimulus(3'b001, 3'd1, 3'd0, 8'h01, 1'b0);
        tick();
        check_output("done_no_we", 32'(mem_we), 32'd0);
        check_output("done_count", 32'(count), 32'(DEPTH));

        // start and a valid bundle in the same cycle: start wins
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check_output("start_win_no_we", 32'(mem_we), 32'd0);
        check_output("start_win_ready", 32'(in_ready), 32'd1);
        check_output("start_win_count", 32'(count), 32'd0);
        check_output("start_win_done", 32'(done), 32'd0);
        tick();
        check_output("start_win_no_we2", 32'(mem_we), 32'd0);

        // Reset between an acceptance and its write
        apply_stimulus(3'b100, 3'd6, 3'd0, 8'hC3, 1'b1);
        tick();
        in_valid = 1'b0;
        check_output("rstmid_we_pending", 32'(mem_we), 32'd1);
        n_reset = 1'b0;
        #1;
        check_output("rstmid_we", 32'(mem_we), 32'd0);
        check_output("rstmid_wdata", 32'(mem_wdata), 32'd0);
        check_output("rstmid_done", 32'(done), 32'd0);
        check_output("rstmid_count", 32'(count), 32'd0);
        check_output("rstmid_ready", 32'(in_ready), 32'd0);
        check_output("rstmid_csum", 32'(checksum), 32'd0);
        tick();
        n_reset = 1'b1;
        tick();
        check_output("rstmid_we_after", 32'(mem_we), 32'd0);
        check_output("rstmid_count_after", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
